// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: load/store size encodings carried
// in funct3, the access-size classification used by the alignment logic,
// and the MEM-stage FSM state type.
package mem_pkg;

  // funct3 access size / signedness encodings
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } ls_size_t;

  // Any funct3 value outside the five defined encodings is a word access.
  function automatic ls_size_t decode_size(input logic [2:0] funct3);
    case (funct3)
      LS_B, LS_BU: return SZ_B;
      LS_H, LS_HU: return SZ_H;
      LS_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (decode_size(funct3))
      SZ_H:    return addr_lo[0];
      SZ_W:    return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the data-memory port (purely combinational).
//   funct3     : access size / signedness
//   addr_lo    : effective address bits [1:0]
//   is_store   : access is a store (otherwise all byte enables are set)
//   store_data : rs2 value to be stored
//   rdata      : raw word returned by data memory
//   be         : byte enables
//   wdata      : store data replicated across all lanes of its size
//   load_data  : extracted and sign/zero-extended load result
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  ls_size_t    size;
  logic        is_unsigned;
  logic [31:0] shifted;

  assign size        = decode_size(funct3);
  assign is_unsigned = funct3[2];
  // Bring the addressed byte down to lane 0 before trimming to size.
  assign shifted     = rdata >> {addr_lo, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    be        = 4'b1111;
    wdata     = store_data;
    load_data = shifted;
    case (size)
      SZ_B: begin
        if (is_store) be = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        if (is_store) be = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage with the MEM/WB register.
// Issues loads/stores on a req/gnt/rvalid data-memory port, stalls the
// upstream pipeline while an access is outstanding, aborts an access that
// stays in REQ/WAIT for TIMEOUT_CYCLES as a bus error, and presents
// registered results and exception flags to writeback.
//   clk, rst            : clock, asynchronous active-high reset
//   *_mem               : EX/MEM control and data (held stable while stall_mem)
//   dmem_*              : data-memory request/response port
//   stall_mem           : MEM instruction cannot retire this cycle
//   *_wb                : registered writeback control, flags and results
module memory_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_mem,
  input  logic        mem_read_mem,
  input  logic        mem_write_mem,
  input  logic        mem_to_reg_mem,
  input  logic        fp_op_mem,
  input  logic        reg_write_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [4:0]  rd_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] store_data_mem,
  input  logic [31:0] fpu_result_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        valid_wb,
  output logic        reg_write_wb,
  output logic        mem_to_reg_wb,
  output logic        fp_op_wb,
  output logic        misalign_wb,
  output logic        bus_err_wb,
  output logic [4:0]  rd_wb,
  output logic [31:0] alu_result_wb,
  output logic [31:0] mem_rdata_wb,
  output logic [31:0] fpu_result_wb
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t  state, state_next;
  logic [CW-1:0] cnt;

  logic        is_mem, is_load, is_store, misalign, timeout;
  logic        req, stall, retire, take_load, flag_misalign, flag_bus_err;
  logic [31:0] load_data;

  assign is_mem   = valid_mem & (mem_read_mem | mem_write_mem);
  // A load wins when both read and write are flagged.
  assign is_load  = mem_read_mem;
  assign is_store = mem_write_mem & ~mem_read_mem;
  assign misalign = is_misaligned(funct3_mem, alu_result_mem[1:0]);
  assign timeout  = (cnt == CW'(TIMEOUT_CYCLES));

  lsu_align u_lsu_align (
    .funct3     (funct3_mem),
    .addr_lo    (alu_result_mem[1:0]),
    .is_store   (is_store),
    .store_data (store_data_mem),
    .rdata      (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_data  (load_data)
  );

  // Request and stall are forced low while reset is asserted, even though an
  // access may still be presented on the *_mem inputs.
  assign dmem_req  = req & ~rst;
  assign dmem_we   = dmem_req & is_store;
  assign dmem_addr = {alu_result_mem[31:2], 2'b00};
  assign stall_mem = stall & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Timeout counter runs only while an access is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    cnt <= '0;
    else if (state == IDLE || state_next == IDLE) cnt <= '0;
    else                                        cnt <= cnt + CW'(1);
  end

  always_comb begin
    state_next    = state;
    req           = 1'b0;
    stall         = 1'b0;
    retire        = 1'b0;
    take_load     = 1'b0;
    flag_misalign = 1'b0;
    flag_bus_err  = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          if (misalign) begin
            retire        = 1'b1;
            flag_misalign = 1'b1;
          end else begin
            req = 1'b1;
            if (dmem_gnt && !is_load) begin
              retire = 1'b1;
            end else begin
              stall      = 1'b1;
              state_next = dmem_gnt ? WAIT : REQ;
            end
          end
        end else if (valid_mem) begin
          retire = 1'b1;
        end
      end
      REQ: begin
        req = 1'b1;
        if (timeout) begin
          retire       = 1'b1;
          flag_bus_err = 1'b1;
          state_next   = IDLE;
        end else if (dmem_gnt) begin
          if (is_load) begin
            stall      = 1'b1;
            state_next = WAIT;
          end else begin
            retire     = 1'b1;
            state_next = IDLE;
          end
        end else begin
          stall = 1'b1;
        end
      end
      WAIT: begin
        if (timeout) begin
          retire       = 1'b1;
          flag_bus_err = 1'b1;
          state_next   = IDLE;
        end else if (dmem_rvalid) begin
          retire     = 1'b1;
          take_load  = 1'b1;
          state_next = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // MEM/WB register: a retiring instruction is captured; anything else
  // (stall cycle or empty slot) becomes an all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !retire) begin
      valid_wb      <= 1'b0;
      reg_write_wb  <= 1'b0;
      mem_to_reg_wb <= 1'b0;
      fp_op_wb      <= 1'b0;
      misalign_wb   <= 1'b0;
      bus_err_wb    <= 1'b0;
      rd_wb         <= '0;
      alu_result_wb <= '0;
      mem_rdata_wb  <= '0;
      fpu_result_wb <= '0;
    end else begin
      valid_wb      <= 1'b1;
      reg_write_wb  <= reg_write_mem & ~flag_misalign & ~flag_bus_err;
      mem_to_reg_wb <= mem_to_reg_mem;
      fp_op_wb      <= fp_op_mem;
      misalign_wb   <= flag_misalign;
      bus_err_wb    <= flag_bus_err;
      rd_wb         <= rd_mem;
      alu_result_wb <= alu_result_mem;
      mem_rdata_wb  <= take_load ? load_data : 32'h0;
      fpu_result_wb <= fpu_result_mem;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios followed by
// random instructions checked against a transaction-level reference model.
module tb_memory_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_mem, mem_read_mem, mem_write_mem, mem_to_reg_mem, fp_op_mem, reg_write_mem;
  logic [2:0]  funct3_mem;
  logic [4:0]  rd_mem;
  logic [31:0] alu_result_mem, store_data_mem, fpu_result_mem;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_mem, valid_wb, reg_write_wb, mem_to_reg_wb, fp_op_wb, misalign_wb, bus_err_wb;
  logic [4:0]  rd_wb;
  logic [31:0] alu_result_wb, mem_rdata_wb, fpu_result_wb;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .valid_mem(valid_mem), .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .mem_to_reg_mem(mem_to_reg_mem), .fp_op_mem(fp_op_mem), .reg_write_mem(reg_write_mem),
    .funct3_mem(funct3_mem), .rd_mem(rd_mem), .alu_result_mem(alu_result_mem),
    .store_data_mem(store_data_mem), .fpu_result_mem(fpu_result_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_mem(stall_mem), .valid_wb(valid_wb), .reg_write_wb(reg_write_wb),
    .mem_to_reg_wb(mem_to_reg_wb), .fp_op_wb(fp_op_wb), .misalign_wb(misalign_wb),
    .bus_err_wb(bus_err_wb), .rd_wb(rd_wb), .alu_result_wb(alu_result_wb),
    .mem_rdata_wb(mem_rdata_wb), .fpu_result_wb(fpu_result_wb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One instruction as seen by the stage, plus the memory's response timing:
  // g = cycles gnt stays low before it is given, r = cycles after the cycle
  // following the grant before rvalid arrives.
  typedef struct {
    logic        valid, rd_en, wr_en, m2r, fp, rw;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, sdata, fres, rdata;
    int          g, r;
  } instr_t;

  typedef struct {
    int          done_idx;   // cycle index (0 = first cycle in MEM) at which it retires
    logic        issue, misal, berr, rw;
    logic [31:0] rdata_wb;
  } pred_t;

  function automatic int size_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic pred_t predict(input instr_t in);
    pred_t       p;
    int          sz, lo, done;
    logic [31:0] val;
    p.done_idx = 0; p.issue = 0; p.misal = 0; p.berr = 0; p.rw = 0; p.rdata_wb = '0;
    sz = size_bytes(in.f3);
    lo = int'(in.addr[1:0]);
    if (in.valid && (in.rd_en || in.wr_en)) begin
      p.misal = (lo % sz) != 0;
      if (!p.misal) begin
        p.issue = 1;
        done = in.rd_en ? in.g + 1 + in.r : in.g;
        // Outstanding cycle k (k >= 1) sees count k-1; count T aborts.
        if (done > T) begin
          p.berr = 1;
          done   = T + 1;
        end
        p.done_idx = done;
        if (in.rd_en && !p.berr) begin
          val = '0;
          for (int k = 0; k < sz; k++) val[8*k +: 8] = in.rdata[8*(lo+k) +: 8];
          if (sz < 4 && !in.f3[2] && val[8*sz-1]) val = val | ~((32'h1 << (8*sz)) - 32'h1);
          p.rdata_wb = val;
        end
      end
    end
    p.rw = in.valid && in.rw && !p.misal && !p.berr;
    return p;
  endfunction

  // Observations kept for the directed scenarios.
  int          g_stalls, g_wb, g_req_cycles;
  logic [31:0] g_addr, g_wdata;
  logic [3:0]  g_be;
  logic        g_we;

  // Drives one instruction starting at a falling edge and ends at the
  // falling edge after it retires.
  task automatic run_instr(input instr_t in);
    pred_t       p;
    logic        exp_req, rv_cycle;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          sz, lo;
    p  = predict(in);
    sz = size_bytes(in.f3);
    lo = int'(in.addr[1:0]);
    for (int lane = 0; lane < 4; lane++) begin
      exp_be[lane]        = in.rd_en ? 1'b1 : (lane >= lo && lane < lo + sz);
      exp_wd[8*lane +: 8] = in.sdata[8*(lane % sz) +: 8];
    end
    valid_mem = in.valid; mem_read_mem = in.rd_en; mem_write_mem = in.wr_en;
    mem_to_reg_mem = in.m2r; fp_op_mem = in.fp; reg_write_mem = in.rw;
    funct3_mem = in.f3; rd_mem = in.rd; alu_result_mem = in.addr;
    store_data_mem = in.sdata; fpu_result_mem = in.fres;
    g_stalls = 0; g_wb = 0; g_req_cycles = 0;
    for (int idx = 0; idx <= p.done_idx; idx++) begin
      rv_cycle    = p.issue && in.rd_en && (idx == in.g + 1 + in.r);
      dmem_gnt    = p.issue && (idx == in.g);
      // rvalid noise is only injected while no read response is expected.
      dmem_rvalid = rv_cycle || ((!p.issue || !in.rd_en || idx <= in.g) && ($urandom_range(0, 1) == 1));
      dmem_rdata  = rv_cycle ? in.rdata : $urandom();
      exp_req     = p.issue && (idx <= in.g);
      #1;
      check("dmem_req", dmem_req, exp_req);
      check("stall_mem", stall_mem, idx < p.done_idx);
      if (exp_req) begin
        check("dmem_addr", dmem_addr, {in.addr[31:2], 2'b00});
        check("dmem_we", dmem_we, !in.rd_en);
        check("dmem_be", dmem_be, exp_be);
        if (!in.rd_en) check("dmem_wdata", dmem_wdata, exp_wd);
      end
      if (dmem_req) begin
        g_req_cycles++;
        g_addr = dmem_addr; g_wdata = dmem_wdata; g_be = dmem_be; g_we = dmem_we;
      end
      if (stall_mem) g_stalls++;
      @(posedge clk);
      @(negedge clk);
      if (valid_wb) g_wb++;
      if (idx < p.done_idx || !in.valid) begin
        check("bubble_valid", valid_wb, 0);
        check("bubble_rw", reg_write_wb, 0);
      end else begin
        check("wb_valid", valid_wb, 1);
        check("wb_rw", reg_write_wb, p.rw);
        check("wb_rd", rd_wb, in.rd);
        check("wb_alu", alu_result_wb, in.addr);
        check("wb_fpu", fpu_result_wb, in.fres);
        check("wb_m2r", mem_to_reg_wb, in.m2r);
        check("wb_fp", fp_op_wb, in.fp);
        check("wb_rdata", mem_rdata_wb, p.rdata_wb);
        check("wb_misalign", misalign_wb, p.misal);
        check("wb_bus_err", bus_err_wb, p.berr);
      end
    end
    dmem_gnt = 0; dmem_rvalid = 0;
  endtask

  function automatic instr_t mk(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                                input logic [31:0] addr);
    instr_t in;
    in.valid = 1; in.rd_en = rd_en; in.wr_en = wr_en; in.m2r = rd_en; in.fp = 0;
    in.rw = !wr_en || rd_en; in.f3 = f3; in.rd = 5'd7; in.addr = addr;
    in.sdata = 32'h0; in.fres = 32'hF00DF00D; in.rdata = 32'h0; in.g = 0; in.r = 0;
    return in;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t in;
    int     kind;
    rst = 1;
    valid_mem = 0; mem_read_mem = 0; mem_write_mem = 0; mem_to_reg_mem = 0; fp_op_mem = 0;
    reg_write_mem = 0; funct3_mem = 0; rd_mem = 0; alu_result_mem = 0; store_data_mem = 0;
    fpu_result_mem = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst_valid_wb", valid_wb, 0);
    check("rst_rw_wb", reg_write_wb, 0);
    check("rst_alu_wb", alu_result_wb, 0);
    check("rst_rdata_wb", mem_rdata_wb, 0);
    check("rst_req", dmem_req, 0);
    check("rst_stall", stall_mem, 0);
    rst = 0;

    // ALU op: one-cycle latency, no stall.
    in = mk(0, 0, 3'b000, 32'h12345678);
    run_instr(in);
    check("alu_result", alu_result_wb, 32'h12345678);
    check("alu_stalls", g_stalls, 0);

    // LB / LBU at 0x1003.
    in = mk(1, 0, 3'b000, 32'h1003); in.rdata = 32'h80FFFFFF;
    run_instr(in);
    check("lb_data", mem_rdata_wb, 32'hFFFFFF80);
    check("lb_stalls", g_stalls, 1);
    in.f3 = 3'b100;
    run_instr(in);
    check("lbu_data", mem_rdata_wb, 32'h00000080);
    check("lbu_stalls", g_stalls, 1);

    // SH at 0x2002.
    in = mk(0, 1, 3'b001, 32'h2002); in.sdata = 32'h0000BEEF;
    run_instr(in);
    check("sh_be", g_be, 4'b1100);
    check("sh_wdata", g_wdata, 32'hBEEFBEEF);
    check("sh_addr", g_addr, 32'h2000);
    check("sh_we", g_we, 1);
    check("sh_stalls", g_stalls, 0);

    // LW with gnt low for three cycles.
    in = mk(1, 0, 3'b010, 32'h3000); in.g = 3; in.rdata = 32'hCAFEBABE;
    run_instr(in);
    check("lw_req_cycles", g_req_cycles, 4);
    check("lw_wait_stalls", g_stalls, 4);
    check("lw_wb_entries", g_wb, 1);
    check("lw_wait_data", mem_rdata_wb, 32'hCAFEBABE);

    // Misaligned LW.
    in = mk(1, 0, 3'b010, 32'h3002);
    run_instr(in);
    check("misal_req_cycles", g_req_cycles, 0);
    check("misal_flag", misalign_wb, 1);
    check("misal_rw", reg_write_wb, 0);

    // LW that never gets rvalid.
    in = mk(1, 0, 3'b010, 32'h5000); in.r = 50;
    run_instr(in);
    check("timeout_bus_err", bus_err_wb, 1);
    check("timeout_rw", reg_write_wb, 0);
    check("timeout_stalls", g_stalls, T + 1);

    // Reset while in WAIT, then a late rvalid.
    valid_mem = 1; mem_read_mem = 1; mem_write_mem = 0; reg_write_mem = 1;
    funct3_mem = 3'b010; alu_result_mem = 32'h4000; dmem_gnt = 1;
    @(posedge clk); @(negedge clk);
    dmem_gnt = 0;
    #1;
    check("wait_stall", stall_mem, 1);
    rst = 1;
    #1;
    check("rstw_req", dmem_req, 0);
    check("rstw_we", dmem_we, 0);
    check("rstw_stall", stall_mem, 0);
    check("rstw_valid_wb", valid_wb, 0);
    check("rstw_rw_wb", reg_write_wb, 0);
    check("rstw_rdata_wb", mem_rdata_wb, 0);
    valid_mem = 0;
    @(negedge clk);
    rst = 0;
    dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
    #1;
    check("late_rv_stall", stall_mem, 0);
    @(posedge clk); @(negedge clk);
    check("late_rv_valid_wb", valid_wb, 0);
    check("late_rv_rdata_wb", mem_rdata_wb, 0);
    dmem_rvalid = 0;
    in = mk(0, 0, 3'b000, 32'hA5A5A5A5);
    run_instr(in);

    // Random instruction stream.
    for (int n = 0; n < 300; n++) begin
      kind     = $urandom_range(0, 3);
      in.valid = ($urandom_range(0, 9) != 0);
      in.rd_en = (kind == 1 || kind == 3);
      in.wr_en = (kind == 2 || kind == 3);
      in.m2r   = $urandom_range(0, 1);
      in.fp    = $urandom_range(0, 1);
      in.rw    = $urandom_range(0, 1);
      in.f3    = 3'($urandom_range(0, 7));
      in.rd    = 5'($urandom_range(0, 31));
      in.addr  = $urandom();
      if ($urandom_range(0, 1) == 1) in.addr[1:0] = 2'b00;
      in.sdata = $urandom();
      in.fres  = $urandom();
      in.rdata = $urandom();
      in.g     = $urandom_range(0, 3);
      in.r     = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
      run_instr(in);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage plus MEM/WB register, directly upstream of the writeback mux. It issues load/store requests to a req/gnt/rvalid data-memory port and performs byte-lane alignment with sign/zero extension. It stalls the upstream pipeline while an access is outstanding and presents registered `alu_result_wb`, `mem_rdata_wb`, `fpu_result_wb`, `mem_to_reg_wb` and `fp_op_wb` to the writeback stage.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles in REQ/WAIT before the access is aborted as a bus error.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `valid_mem`, `mem_read_mem`, `mem_write_mem`, `mem_to_reg_mem`, `fp_op_mem`, `reg_write_mem` input 1 each: EX/MEM control.
- `funct3_mem` input 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `rd_mem` input 5: destination register.
- `alu_result_mem` input 32: ALU result, also the effective address.
- `store_data_mem` input 32: store data (rs2).
- `fpu_result_mem` input 32: FPU result.
- `dmem_req`, `dmem_we` output 1 each: request and write enable.
- `dmem_addr` output 32: word-aligned address.
- `dmem_wdata` output 32: lane-replicated store data.
- `dmem_be` output 4: byte enables.
- `dmem_gnt`, `dmem_rvalid` input 1 each: grant and read-data valid.
- `dmem_rdata` input 32: read data.
- `stall_mem` output 1: the MEM instruction cannot retire this cycle; upstream holds all `*_mem` inputs stable while high.
- `valid_wb`, `reg_write_wb`, `mem_to_reg_wb`, `fp_op_wb`, `misalign_wb`, `bus_err_wb` output 1 each: registered WB control and exception flags.
- `rd_wb` output 5: registered destination register.
- `alu_result_wb`, `mem_rdata_wb`, `fpu_result_wb` output 32 each: registered results.

## Operation
- FSM states are IDLE, REQ and WAIT. Reset puts the FSM in IDLE, clears every WB output to 0, holds `dmem_req` at 0 and clears the timeout counter.
- Non-memory instruction, `valid_mem`=1 in IDLE: WB registers load the `*_mem` values with `mem_rdata_wb`=0 and `valid_wb`=1. No stall.
- `valid_mem`=0: WB registers load a bubble (`valid_wb`=0, `reg_write_wb`=0).
- Memory access, `mem_read_mem` or `mem_write_mem` set:
  - Misalignment: W requires addr[1:0]=0; H/HU require addr[0]=0.
  - A misaligned access issues no request. It retires immediately with `misalign_wb`=1 and `reg_write_wb`=0.
  - If both `mem_read_mem` and `mem_write_mem` are set, the load wins.
  - Unlisted `funct3` values are treated as W.
- IDLE, aligned access: `dmem_req`=1 combinationally.
  - `dmem_gnt`=1 on a store: retires this cycle with no stall.
  - `dmem_gnt`=1 on a load: go to WAIT; `stall_mem`=1.
  - `dmem_gnt`=0: go to REQ; `stall_mem`=1.
- REQ: `dmem_req` stays high with the address, data and enables unchanged. On `dmem_gnt`, a store retires and the FSM goes to IDLE; a load goes to WAIT.
- WAIT: `dmem_req`=0. On `dmem_rvalid`, `stall_mem` drops that cycle, `mem_rdata_wb` captures the aligned data, `valid_wb`=1, and the FSM goes to IDLE.
- `dmem_rvalid` outside WAIT is ignored.
- Store lanes:
  - SB: `dmem_be`=1<<addr[1:0]; `dmem_wdata` is the byte replicated ×4.
  - SH: `dmem_be`=0011<<(2·addr[1]); `dmem_wdata` is the halfword replicated ×2.
  - SW: `dmem_be`=1111.
  - Loads drive `dmem_be`=1111 and `dmem_we`=0.
- Load extraction: take `dmem_rdata`>>(8·addr[1:0]), keep 8/16/32 bits, then sign-extend for B/H or zero-extend for BU/HU.
- `dmem_addr` = {addr[31:2], 2'b00}.
- Timeout: the counter increments each cycle in REQ/WAIT and clears in IDLE. At count = `TIMEOUT_CYCLES` the access retires with `bus_err_wb`=1 and `reg_write_wb`=0, and the FSM goes to IDLE.
- Asynchronous reset during REQ or WAIT abandons the access with no retire. A late `dmem_rvalid` after reset is ignored.

## Timing
- Non-memory instruction: 1-cycle MEM→WB latency, zero stall.
- Store with immediate grant: zero stall.
- Load with immediate grant and rvalid on the next cycle: 1 stall cycle; WB data is valid 2 cycles after entering MEM.
- Each extra cycle without `gnt` or `rvalid` adds 1 stall cycle. Each stall cycle pushes a bubble into WB.

## Structure
- A shared package `mem_pkg` holds:
  - the `funct3` size constants (LS_B, LS_H, LS_W, LS_BU, LS_HU);
  - the FSM state enum `mem_state_t`.
- The combinational sub-module `lsu_align` covers store lane/byte-enable generation and load extract/extend. It is instantiated once.

## Test plan
- ALU op `alu_result_mem`=0x12345678, `valid_mem`=1 → next cycle `valid_wb`=1, `alu_result_wb`=0x12345678, `stall_mem` never high.
- LB at addr 0x1003, `dmem_rdata`=0x80FFFFFF, gnt immediate, rvalid 1 cycle later → `mem_rdata_wb`=0xFFFFFF80; LBU at the same address and data → 0x00000080; exactly one stall cycle each.
- SH at addr 0x2002, `store_data_mem`=0x0000BEEF → `dmem_be`=1100, `dmem_wdata`=0xBEEFBEEF, `dmem_addr`=0x2000, `dmem_we`=1.
- LW at 0x3000 with `gnt` low for 3 cycles → `dmem_req` stays high and the address is stable throughout; `stall_mem` high until rvalid; one WB entry only.
- LW at 0x3002 → no `dmem_req`; next cycle `misalign_wb`=1, `reg_write_wb`=0.
- LW granted but rvalid never arrives, `TIMEOUT_CYCLES`=4 → `bus_err_wb`=1 after timeout. Separately, assert `rst` in WAIT → all outputs 0 and FSM in IDLE; a later rvalid produces no retire.
